// File: rtl/div_if.sv
// div_if: request/result bus between the execute stage and the divider.
interface div_if #(parameter int WIDTH = 32);
  logic [2*WIDTH+2:0] es_to_div_bus;
  logic               div_ack;
  logic               flush_ES;
  logic [WIDTH:0]     div_to_es_bus;
  logic               div_busy;
  modport master (output es_to_div_bus, div_ack, flush_ES, input div_to_es_bus, div_busy);
  modport slave  (input es_to_div_bus, div_ack, flush_ES, output div_to_es_bus, div_busy);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, one quotient bit per cycle, result held until acked.
module div_unit #(parameter int WIDTH = 32) (
  input logic  clk,
  input logic  resetn,
  div_if.slave dif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic             req, use_mod_in, uns_in;
  logic [WIDTH-1:0] src1, src2;
  assign {req, use_mod_in, uns_in, src1, src2} = dif.es_to_div_bus;
  logic             use_mod, s1n, s2n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, dvs, result;
  logic             last, ge, s1_in, s2_in;
  logic [WIDTH:0]   sh, rem_n;
  logic [WIDTH-1:0] quo_n, q_fix, r_fix;
  assign last  = cnt == CW'(WIDTH - 1);
  assign s1_in = !uns_in && src1[WIDTH-1];
  assign s2_in = !uns_in && src2[WIDTH-1];
  assign sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign ge    = sh >= {1'b0, dvs};
  assign rem_n = ge ? sh - {1'b0, dvs} : sh;
  assign quo_n = {quo[WIDTH-2:0], ge};
  // A zero divisor leaves rem = |src1|, so the dividend-sign fixup restores the original src1.
  assign q_fix = dvs == '0 ? '1 : (s1n ^ s2n) ? -quo_n : quo_n;
  assign r_fix = s1n ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
  always_comb begin
    state_nx = dif.flush_ES ? IDLE :
               state == IDLE ? (req ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               (dif.div_ack || !req) ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      use_mod <= 1'b0;
      s1n     <= 1'b0;
      s2n     <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      result  <= '0;
    end else if (!dif.flush_ES) begin
      if (state == IDLE && req) begin
        use_mod <= use_mod_in;
        s1n     <= s1_in;
        s2n     <= s2_in;
        quo     <= s1_in ? -src1 : src1;
        dvs     <= s2_in ? -src2 : src2;
        rem     <= '0;
        cnt     <= '0;
      end else if (state == CALC) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (last) result <= use_mod ? r_fix : q_fix;
      end
    end
  end
  assign dif.div_to_es_bus = {result, state == DONE};
  assign dif.div_busy      = state != IDLE;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of latency, signed/unsigned results, hold, flush and async reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  div_if #(.WIDTH(32)) dif();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .dif(dif));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_ok(input string tag, input int exp_ticks);
    int n = 0;
    while (dif.div_to_es_bus[0] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_ticks);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic m, input logic u, input logic [31:0] exp);
    dif.es_to_div_bus = {1'b1, m, u, a, b};
    tick();
    chk({tag, "_busy"}, 32'(dif.div_busy), 32'd1);
    wait_ok(tag, 32);
    chk(tag, dif.div_to_es_bus[32:1], exp);
    dif.es_to_div_bus = '0;
    dif.div_ack = 1'b1;
    tick();
    dif.div_ack = 1'b0;
    chk({tag, "_okclr"}, 32'(dif.div_to_es_bus[0]), 32'd0);
  endtask
  initial begin
    int seen;
    dif.es_to_div_bus = '0;
    dif.div_ack = 1'b0;
    dif.flush_ES = 1'b0;
    #12;
    chk("rst_bus", dif.div_to_es_bus[31:0], 32'd0);
    chk("rst_busy", 32'(dif.div_busy), 32'd0);
    resetn = 1'b1;
    tick();
    run("u_div", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14);
    run("u_mod", 32'd100, 32'd7, 1'b1, 1'b1, 32'd2);
    run("u_big", 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'h7FFFFFFC);
    run("s_div_nd", 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'hFFFFFFFD);
    run("s_mod_nd", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF);
    run("s_div_nv", 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFFFFFD);
    run("s_mod_nv", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd1);
    run("ovf_div", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000);
    run("ovf_mod", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0);
    run("dz_div", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF);
    run("dz_mod", 32'd5, 32'd0, 1'b1, 1'b0, 32'd5);
    run("dz_div_neg", 32'hFFFFFFFB, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF);
    run("dz_mod_neg", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFB);
    // Hold in DONE while req stays high without ack.
    dif.es_to_div_bus = {1'b1, 1'b0, 1'b1, 32'd100, 32'd7};
    tick();
    wait_ok("hold", 32);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_ok", 32'(dif.div_to_es_bus[0]), 32'd1);
      chk("hold_res", dif.div_to_es_bus[32:1], 32'd14);
    end
    dif.div_ack = 1'b1;
    dif.es_to_div_bus = {1'b1, 1'b0, 1'b1, 32'd9, 32'd3};
    tick();
    dif.div_ack = 1'b0;
    chk("ack_okclr", 32'(dif.div_to_es_bus[0]), 32'd0);
    chk("ack_idle", 32'(dif.div_busy), 32'd0);
    tick();
    wait_ok("b2b", 32);
    chk("b2b_res", dif.div_to_es_bus[32:1], 32'd3);
    dif.es_to_div_bus = '0;
    tick();
    // Flush mid-CALC.
    dif.es_to_div_bus = {1'b1, 1'b0, 1'b1, 32'd100, 32'd7};
    tick();
    dif.es_to_div_bus = '0;
    repeat (15) tick();
    dif.flush_ES = 1'b1;
    tick();
    dif.flush_ES = 1'b0;
    chk("flush_busy", 32'(dif.div_busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.div_to_es_bus[0] === 1'b1) seen++;
    end
    chk("flush_no_ok", seen, 0);
    run("post_flush", 32'd9, 32'd3, 1'b0, 1'b1, 32'd3);
    // Flush together with req in IDLE must not start.
    dif.es_to_div_bus = {1'b1, 1'b0, 1'b1, 32'd9, 32'd3};
    dif.flush_ES = 1'b1;
    tick();
    dif.flush_ES = 1'b0;
    dif.es_to_div_bus = '0;
    chk("flush_req_idle", 32'(dif.div_busy), 32'd0);
    tick();
    // Async reset between edges.
    dif.es_to_div_bus = {1'b1, 1'b0, 1'b1, 32'd100, 32'd7};
    tick();
    repeat (10) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(dif.div_busy), 32'd0);
    chk("arst_ok", 32'(dif.div_to_es_bus[0]), 32'd0);
    chk("arst_res", dif.div_to_es_bus[32:1], 32'd0);
    dif.es_to_div_bus = '0;
    tick();
    resetn = 1'b1;
    tick();
    run("post_rst", 32'd9, 32'd3, 1'b1, 1'b1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
